entropy_conditioner: RTL

ENTROPY_CONDITIONER -- requirements
Module: entropy_conditioner

---
 rtl/entropy_conditioner.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/entropy_conditioner.sv
// entropy_conditioner
//   Turns a set of free-running ring-oscillator outputs into fixed-width random
//   words. Each source is synchronised. The XOR of all sources is sampled once
//   every SAMPLE_DIVIDER clocks. A repetition-count health test watches the raw
//   bits. Optional von Neumann debiasing follows, and the surviving bits are
//   packed MSB-first into words behind a one-entry valid/ready output register.
//
// Ports
//   clkIn        : single clock, rising edge
//   rstN         : synchronous active-low reset
//   enable       : run the sampler; low clears the in-progress word and pending bit
//   vnEnable     : 1 = von Neumann debiasing, 0 = raw bits forwarded
//   roIn         : asynchronous oscillator outputs, NUM_SOURCES wide
//   wordData     : assembled word, held while unconsumed and after consumption
//   wordValid    : wordData holds an unconsumed word
//   wordReady    : consumer takes the word on an edge where wordValid is high
//   healthFail   : sticky repetition-test failure; blocks all later bits
//   overrunCount : saturating count of words dropped because the output was full
module entropy_conditioner #(
    parameter int NUM_SOURCES    = 5,
    parameter int SAMPLE_DIVIDER = 27,
    parameter int WORD_WIDTH     = 8,
    parameter int REP_LIMIT      = 32
) (
    input  logic                   clkIn,
    input  logic                   rstN,
    input  logic                   enable,
    input  logic                   vnEnable,
    input  logic [NUM_SOURCES-1:0] roIn,
    output logic [WORD_WIDTH-1:0]  wordData,
    output logic                   wordValid,
    input  logic                   wordReady,
    output logic                   healthFail,
    output logic [7:0]             overrunCount
);

    localparam int CNT_W = $clog2(SAMPLE_DIVIDER);
    localparam int RUN_W = $clog2(REP_LIMIT + 1);
    localparam int BIT_W = $clog2(WORD_WIDTH);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIVIDER - 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(REP_LIMIT);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_WIDTH - 1);

    logic [NUM_SOURCES-1:0] ro_meta;
    logic [NUM_SOURCES-1:0] ro_sync;
    logic [CNT_W-1:0]       samp_cnt;
    logic                   tick;

    logic                   raw_bit_p0;
    logic                   vld_p0;

    logic [RUN_W-1:0]       run_len;
    logic                   last_bit;
    logic                   pend_bit;
    logic                   pend_vld;
    logic                   vn_q;
    logic [WORD_WIDTH-1:0]  asm_word;
    logic [BIT_W-1:0]       bit_cnt;

    logic                   proc_p0;
    logic [RUN_W-1:0]       run_next;
    logic                   hit_limit;
    logic                   pass;
    logic                   pend_live;
    logic                   fwd_vld;
    logic                   fwd_bit;
    logic [WORD_WIDTH-1:0]  word_next;
    logic                   word_done;
    logic                   out_free;

    assign tick = enable && (samp_cnt == CNT_LAST);

    // ---- stage 0: synchronise sources and sample the combined raw bit on tick ----
    always_ff @(posedge clkIn) begin
        if (!rstN) begin
            ro_meta    <= '0;
            ro_sync    <= '0;
            samp_cnt   <= '0;
            raw_bit_p0 <= 1'b0;
            vld_p0     <= 1'b0;
        end else begin
            ro_meta <= roIn;
            ro_sync <= ro_meta;
            if (!enable || samp_cnt == CNT_LAST) begin
                samp_cnt <= '0;
            end else begin
                samp_cnt <= samp_cnt + CNT_W'(1);
            end
            vld_p0 <= tick;
            if (tick) begin
                raw_bit_p0 <= ^ro_sync;
            end
        end
    end

    // ---- stage 1: health test, debiasing and word assembly ----
    always_comb begin
        proc_p0  = vld_p0 && enable;
        run_next = RUN_W'(1);
        // run_len == 0 marks "no previous bit" so the first bit starts a run of 1
        if (run_len != '0 && raw_bit_p0 == last_bit) begin
            run_next = (run_len == RUN_MAX) ? RUN_MAX : run_len + RUN_W'(1);
        end
        hit_limit = (run_next == RUN_MAX);
        pass      = proc_p0 && !healthFail && !hit_limit;
        // a pending bit captured under the other vnEnable setting is stale
        pend_live = pend_vld && (vnEnable == vn_q);
        fwd_vld   = 1'b0;
        fwd_bit   = raw_bit_p0;
        if (!vnEnable) begin
            fwd_vld = pass;
        end else if (pass && pend_live && (pend_bit != raw_bit_p0)) begin
            fwd_vld = 1'b1;
            fwd_bit = pend_bit;
        end
        word_next = {asm_word[WORD_WIDTH-2:0], fwd_bit};
        word_done = fwd_vld && (bit_cnt == BIT_LAST);
        out_free  = !wordValid || wordReady;
    end

    always_ff @(posedge clkIn) begin
        if (!rstN) begin
            run_len    <= '0;
            last_bit   <= 1'b0;
            healthFail <= 1'b0;
            pend_bit   <= 1'b0;
            pend_vld   <= 1'b0;
            vn_q       <= 1'b0;
            asm_word   <= '0;
            bit_cnt    <= '0;
        end else begin
            vn_q <= vnEnable;
            if (proc_p0) begin
                run_len  <= run_next;
                last_bit <= raw_bit_p0;
                if (hit_limit) begin
                    healthFail <= 1'b1;
                end
            end
            if (!enable || vnEnable != vn_q) begin
                pend_vld <= 1'b0;
            end else if (vnEnable && pass) begin
                pend_vld <= !pend_vld;
                if (!pend_vld) begin
                    pend_bit <= raw_bit_p0;
                end
            end
            if (!enable) begin
                asm_word <= '0;
                bit_cnt  <= '0;
            end else if (fwd_vld) begin
                asm_word <= word_next;
                bit_cnt  <= word_done ? '0 : bit_cnt + BIT_W'(1);
            end
        end
    end

    // ---- output register: one-entry valid/ready holding slot ----
    always_ff @(posedge clkIn) begin
        if (!rstN) begin
            wordData     <= '0;
            wordValid    <= 1'b0;
            overrunCount <= '0;
        end else begin
            if (word_done && out_free) begin
                wordData  <= word_next;
                wordValid <= 1'b1;
            end else if (wordValid && wordReady) begin
                wordValid <= 1'b0;
            end
            if (word_done && !out_free && overrunCount != 8'hFF) begin
                overrunCount <= overrunCount + 8'd1;
            end
        end
    end

endmodule
